// File: rtl/conv_window_5x5_if.sv
// conv_window_5x5_if: pixel-in handshake and window-out bus; master drives pixels/start, slave (window generator) drives ready and window outputs
interface conv_window_5x5_if #(
  parameter int DATA_WIDTH = 12
);
  logic                          start;
  logic signed [DATA_WIDTH-1:0]  pixel_in;
  logic                          pixel_in_valid;
  logic                          pixel_in_ready;
  logic [25*DATA_WIDTH-1:0]      window_out;
  logic                          window_valid;
  logic [4:0]                    out_row;
  logic [4:0]                    out_col;
  logic                          frame_done;
  modport master (
    output start, pixel_in, pixel_in_valid,
    input  pixel_in_ready, window_out, window_valid, out_row, out_col, frame_done
  );
  modport slave (
    input  start, pixel_in, pixel_in_valid,
    output pixel_in_ready, window_out, window_valid, out_row, out_col, frame_done
  );
endinterface

// File: rtl/conv_window_5x5.sv
// conv_window_5x5: streaming 5x5 sliding-window generator (clk, rst, cw: pixel stream in, 25-element window + coordinates out)
module conv_window_5x5 #(
  parameter int DATA_WIDTH    = 12,
  parameter int INPUT_WIDTH   = 32,
  parameter int INPUT_HEIGTH  = 32,
  parameter int FILTER_SIZE   = 5,
  parameter int OUTPUT_WIDTH  = INPUT_WIDTH - FILTER_SIZE + 1,
  parameter int OUTPUT_HEIGTH = INPUT_HEIGTH - FILTER_SIZE + 1
) (
  input logic              clk,
  input logic              rst,
  conv_window_5x5_if.slave cw
);
  localparam int CW = $clog2(INPUT_WIDTH);
  localparam int RW = $clog2(INPUT_HEIGTH);
  localparam logic [CW-1:0] C_LAST = CW'(INPUT_WIDTH - 1);
  localparam logic [RW-1:0] R_LAST = RW'(INPUT_HEIGTH - 1);
  localparam logic [CW-1:0] C_MIN  = CW'(INPUT_WIDTH - OUTPUT_WIDTH);
  localparam logic [RW-1:0] R_MIN  = RW'(INPUT_HEIGTH - OUTPUT_HEIGTH);
  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t                        state_q;
  logic [CW-1:0]                 c_q;
  logic [RW-1:0]                 r_q;
  logic                          ready_q, done_q, valid_q;
  logic [4:0]                    orow_q, ocol_q;
  logic [24:0][DATA_WIDTH-1:0]   win_q, win_d, out_q;
  logic [DATA_WIDTH-1:0]         lb_q [4][INPUT_WIDTH];
  logic                          acc, hit;
  // ready is high exactly while ACTIVE, so it doubles as the accept qualifier
  assign acc = ready_q & cw.pixel_in_valid;
  assign hit = acc & (r_q >= R_MIN) & (c_q >= C_MIN);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      c_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (cw.start) begin
          state_q <= ACTIVE;
          ready_q <= 1'b1;
          r_q     <= '0;
          c_q     <= '0;
        end
        ACTIVE: if (acc) begin
          c_q <= (c_q == C_LAST) ? '0 : c_q + 1'b1;
          if (c_q == C_LAST) r_q <= r_q + 1'b1;
          if (c_q == C_LAST && r_q == R_LAST) begin
            state_q <= DONE;
            ready_q <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  // window shifts left one column; the new rightmost column is the four buffered rows above plus the incoming pixel
  always_comb begin
    win_d     = {DATA_WIDTH'(0), win_q[24:1]};
    win_d[4]  = lb_q[0][c_q];
    win_d[9]  = lb_q[1][c_q];
    win_d[14] = lb_q[2][c_q];
    win_d[19] = lb_q[3][c_q];
    win_d[24] = cw.pixel_in;
  end
  // line buffers: index 3 holds row r-1, index 0 holds row r-4; each accept ages column c by one row
  always_ff @(posedge clk) begin
    if (acc) begin
      lb_q[0][c_q] <= lb_q[1][c_q];
      lb_q[1][c_q] <= lb_q[2][c_q];
      lb_q[2][c_q] <= lb_q[3][c_q];
      lb_q[3][c_q] <= cw.pixel_in;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      orow_q  <= '0;
      ocol_q  <= '0;
    end else begin
      valid_q <= hit;
      if (acc) win_q <= win_d;
      if (hit) begin
        out_q  <= win_d;
        orow_q <= 5'(r_q - R_MIN);
        ocol_q <= 5'(c_q - C_MIN);
      end
    end
  end
  assign cw.pixel_in_ready = ready_q;
  assign cw.window_out     = out_q;
  assign cw.window_valid   = valid_q;
  assign cw.out_row        = orow_q;
  assign cw.out_col        = ocol_q;
  assign cw.frame_done     = done_q;
endmodule

// File: tb/tb_conv_window_5x5.sv
// tb_conv_window_5x5: randomized self-checking bench for conv_window_5x5 against an image-indexing window model
module tb_conv_window_5x5;
  localparam int DW = 12;
  logic clk = 1'b0;
  logic rst = 1'b1;
  conv_window_5x5_if #(.DATA_WIDTH(DW)) bus ();
  conv_window_5x5 #(.DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .cw(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] img [32][32];
  int pulses, fdone, first_acc;
  logic [DW-1:0] first_e0, first_e24, e24_0_27, last_e24;
  bit final_with_done;

  task automatic fill(input int mode);
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 32; c++)
        img[r][c] = (mode == 0) ? DW'(r * 32 + c) : (mode == 1) ? {DW{1'b1}} : DW'($urandom);
  endtask

  task automatic run_frame(input int drop, input int abort_after, input bit poke_start);
    int r = 0, c = 0, pr = 0, pc = 0, acc_cnt = 0, cyc = 0, tail = 0;
    bit acc_prev = 0, acc_now, exp_v;
    logic [25*DW-1:0] exp_w;
    pulses = 0; fdone = 0; first_acc = 0; final_with_done = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    forever begin
      exp_v = acc_prev && pr >= 4 && pc >= 4;
      checks++;
      if (bus.window_valid !== exp_v) begin
        errors++;
        $display("FAIL window_valid t=%0t got %b expected %b", $time, bus.window_valid, exp_v);
      end
      checks++;
      if (bus.pixel_in_ready !== (acc_cnt < 1024)) begin
        errors++;
        $display("FAIL pixel_in_ready t=%0t got %b expected %b", $time, bus.pixel_in_ready, acc_cnt < 1024);
      end
      if (exp_v && bus.window_valid === 1'b1) begin
        for (int i = 0; i < 5; i++)
          for (int j = 0; j < 5; j++)
            exp_w[(i*5+j)*DW +: DW] = img[pr-4+i][pc-4+j];
        checks++;
        if ({bus.out_row, bus.out_col, bus.window_out} !== {5'(pr - 4), 5'(pc - 4), exp_w}) begin
          errors++;
          $display("FAIL window (%0d,%0d) got row %0d col %0d data %h expected data %h",
                   pr - 4, pc - 4, bus.out_row, bus.out_col, bus.window_out, exp_w);
        end
        if (pulses == 0) begin
          first_acc = acc_cnt;
          first_e0  = bus.window_out[0 +: DW];
          first_e24 = bus.window_out[24*DW +: DW];
        end
        if (pr == 4 && pc == 31) e24_0_27 = bus.window_out[24*DW +: DW];
        if (pr == 31 && pc == 31) last_e24 = bus.window_out[24*DW +: DW];
        pulses++;
      end
      if (bus.frame_done === 1'b1) begin
        fdone++;
        final_with_done = exp_v && pr == 31 && pc == 31 && bus.window_valid === 1'b1;
      end
      if (abort_after > 0 && acc_cnt == abort_after) begin
        bus.pixel_in_valid = 1'b0;
        bus.start = 1'b0;
        return;
      end
      if (acc_cnt == 1024) tail++;
      if (tail == 4) break;
      bus.pixel_in_valid = (acc_cnt < 1024) ? ($urandom_range(99) >= drop) : 1'($urandom_range(1));
      bus.pixel_in = (bus.pixel_in_valid && acc_cnt < 1024) ? img[r][c] : DW'($urandom);
      bus.start = poke_start && ((acc_cnt < 1024 && $urandom_range(9) == 0) || tail == 1);
      acc_now = bus.pixel_in_valid && acc_cnt < 1024;
      if (acc_now) begin
        pr = r; pc = c;
        c++;
        if (c == 32) begin c = 0; r++; end
        acc_cnt++;
      end
      acc_prev = acc_now;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 6000) begin
        errors++;
        $display("FAIL frame_timeout accepted %0d expected 1024", acc_cnt);
        break;
      end
    end
    bus.start = 1'b0;
    bus.pixel_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.start = 1'($urandom_range(1));
      bus.pixel_in_valid = 1'($urandom_range(1));
      bus.pixel_in = DW'($urandom);
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.pixel_in_ready, bus.window_valid, bus.frame_done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 000", {bus.pixel_in_ready, bus.window_valid, bus.frame_done});
    end
    checks++;
    if (bus.window_out !== '0) begin
      errors++;
      $display("FAIL reset_window got %h expected 0", bus.window_out);
    end
    checks++;
    if ({bus.out_row, bus.out_col} !== 10'd0) begin
      errors++;
      $display("FAIL reset_coords got %0d,%0d expected 0,0", bus.out_row, bus.out_col);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.pixel_in_valid = 1'($urandom_range(1));
      bus.pixel_in = DW'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({bus.pixel_in_ready, bus.window_valid, bus.frame_done} !== 3'b000) begin
        errors++;
        $display("FAIL idle_hold got %b expected 000", {bus.pixel_in_ready, bus.window_valid, bus.frame_done});
      end
    end
    bus.pixel_in_valid = 1'b0;
  endtask

  task automatic test_frame;
    fill(0);
    run_frame(0, 0, 1'b0);
    checks++;
    if (pulses != 784) begin errors++; $display("FAIL frame_pulses got %0d expected 784", pulses); end
    checks++;
    if (fdone != 1) begin errors++; $display("FAIL frame_done_count got %0d expected 1", fdone); end
    checks++;
    if (first_acc != 133) begin errors++; $display("FAIL first_window_pixel got %0d expected 133", first_acc); end
    checks++;
    if ({first_e0, first_e24} !== {DW'(0), DW'(132)}) begin
      errors++;
      $display("FAIL first_window_elems got %0d,%0d expected 0,132", first_e0, first_e24);
    end
    checks++;
    if (e24_0_27 !== DW'(159)) begin errors++; $display("FAIL win_0_27_e24 got %0d expected 159", e24_0_27); end
    checks++;
    if (last_e24 !== DW'(1023)) begin errors++; $display("FAIL last_e24 got %0d expected 1023", last_e24); end
    checks++;
    if (!final_with_done) begin errors++; $display("FAIL final_with_done got 0 expected 1"); end
  endtask

  task automatic test_stall;
    fill(0);
    run_frame(40, 0, 1'b0);
    checks++;
    if (pulses != 784 || fdone != 1) begin
      errors++;
      $display("FAIL stall_frame got pulses %0d done %0d expected 784 1", pulses, fdone);
    end
  endtask

  task automatic test_reset_mid;
    fill(2);
    run_frame(25, 500, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.pixel_in_ready, bus.window_valid, bus.frame_done, bus.out_row, bus.out_col} !== 13'd0 ||
        bus.window_out !== '0) begin
      errors++;
      $display("FAIL mid_reset got ready %b valid %b done %b row %0d col %0d win %h expected all 0",
               bus.pixel_in_ready, bus.window_valid, bus.frame_done, bus.out_row, bus.out_col, bus.window_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    fill(1);
    run_frame(30, 0, 1'b0);
    checks++;
    if (pulses != 784 || fdone != 1 || last_e24 !== 12'hFFF) begin
      errors++;
      $display("FAIL neg_frame got pulses %0d done %0d last %h expected 784 1 fff", pulses, fdone, last_e24);
    end
  endtask

  task automatic test_back_to_back;
    fill(2);
    run_frame(20, 0, 1'b1);
    checks++;
    if (pulses != 784 || fdone != 1) begin
      errors++;
      $display("FAIL poke_start got pulses %0d done %0d expected 784 1", pulses, fdone);
    end
    run_frame(20, 0, 1'b0);
    checks++;
    if (pulses != 784 || fdone != 1) begin
      errors++;
      $display("FAIL second_frame got pulses %0d done %0d expected 784 1", pulses, fdone);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pixel_in_valid = 1'b0;
    bus.pixel_in = '0;
    test_reset;
    test_frame;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
